// File: rtl/xor_stream_pkg.sv
// xor_stream_pkg
//   Shared definitions for the stream scrambler/descrambler pair: word width,
//   Galois tap mask, default seed and the one-step LFSR advance function.
//   Both ends import this package so their keystreams cannot diverge.
package xor_stream_pkg;

  localparam int unsigned XS_WIDTH        = 32;
  localparam logic [31:0] XS_POLY         = 32'h8020_0003; // x^32+x^22+x^2+x+1
  localparam logic [31:0] XS_SEED_DEFAULT = 32'hACE1_2345;

  typedef logic [XS_WIDTH-1:0] xs_word_t;

  // Galois right-shift step: shift out bit 0, fold taps back in when it was set.
  function automatic xs_word_t lfsr_step(input xs_word_t s, input xs_word_t poly = XS_POLY);
    lfsr_step = {1'b0, s[XS_WIDTH-1:1]} ^ (s[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/lfsr_keystream_32.sv
// lfsr_keystream_32
//   32-bit Galois LFSR keystream register.
//   Ports:
//     clk      in  1   rising-edge clock
//     reset    in  1   synchronous active-high, state returns to SEED
//     load     in  1   load load_val (priority over advance)
//     load_val in  32  value to load
//     advance  in  1   step the LFSR once
//     key      out 32  current keystream word
module lfsr_keystream_32
  import xor_stream_pkg::*;
#(
  parameter logic [31:0] SEED = XS_SEED_DEFAULT,
  parameter logic [31:0] POLY = XS_POLY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        advance,
  output logic [31:0] key
);

  logic [31:0] r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= load_val;
    end else if (advance) begin
      r_state <= lfsr_step(r_state, POLY);
    end
  end

  assign key = r_state;

endmodule

// File: rtl/xor_stream_decoder.sv
// xor_stream_decoder
//   Receive-side stream descrambler: out_data = in_data ^ keystream, one output
//   register, 1-cycle latency, 1 word/clk, valid/ready on both sides.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     seed_load, seed_in    restart keystream from seed_in (0 selects SEED)
//     in_valid/in_ready/in_data     ciphertext input handshake
//     out_valid/out_ready/out_data  plaintext output handshake
//     word_cnt              words decoded since reset/seed_load (wraps)
//   Build option XOR_DEC_PARITY_EN: adds in_parity (in) and out_perr (out),
//   an even-parity error flag over the ciphertext that travels with out_data.
module xor_stream_decoder
  import xor_stream_pkg::*;
#(
  parameter int unsigned WIDTH = XS_WIDTH,
  parameter logic [31:0] SEED  = XS_SEED_DEFAULT,
  parameter logic [31:0] POLY  = XS_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      word_cnt
`ifdef XOR_DEC_PARITY_EN
  ,
  input  logic             in_parity,
  output logic             out_perr
`endif
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [15:0]      r_word_cnt;
  logic             w_accept;
  logic [WIDTH-1:0] w_key;
  logic [WIDTH-1:0] w_seed_val;

  // seed_load blocks acceptance so the restarted keystream never mixes with
  // a word taken in the same cycle.
  assign in_ready   = !seed_load && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_seed_val = (seed_in == '0) ? SEED : seed_in;

  lfsr_keystream_32 #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_keystream (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (w_seed_val),
    .advance  (w_accept),
    .key      (w_key)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_word_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_out_data  <= in_data ^ w_key;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (seed_load) begin
        r_word_cnt <= '0;
      end else if (w_accept) begin
        r_word_cnt <= r_word_cnt + 16'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign word_cnt  = r_word_cnt;

`ifdef XOR_DEC_PARITY_EN
  logic r_out_perr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_perr <= 1'b0;
    end else if (w_accept) begin
      r_out_perr <= (^in_data) ^ in_parity;
    end
  end

  assign out_perr = r_out_perr;
`endif

endmodule

// File: tb/tb_xor_stream_decoder.sv
module tb_xor_stream_decoder;

  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seed_load = 1'b0;
  logic [31:0] seed_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [15:0] word_cnt;
`ifdef XOR_DEC_PARITY_EN
  logic        in_parity = 1'b0;
  logic        out_perr;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xor_stream_decoder #(
    .SEED (SEED),
    .POLY (POLY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .word_cnt  (word_cnt)
`ifdef XOR_DEC_PARITY_EN
    ,
    .in_parity (in_parity),
    .out_perr  (out_perr)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: keystream as a plain shift/XOR recurrence, pending
  // output words as a queue of {perr, plaintext}.
  function automatic logic [31:0] model_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  logic [32:0] mq[$];
  logic [31:0] m_lfsr = SEED;
  logic [15:0] m_cnt = '0;
  logic        m_acc;
  logic        m_par;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_lfsr = SEED;
      m_cnt  = '0;
    end else begin
      m_acc = in_valid && !seed_load && (mq.size() == 0 || out_ready);
`ifdef XOR_DEC_PARITY_EN
      m_par = (^in_data) ^ in_parity;
`else
      m_par = 1'b0;
`endif
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (seed_load) begin
        m_lfsr = (seed_in == 32'h0) ? SEED : seed_in;
        m_cnt  = '0;
      end else if (m_acc) begin
        mq.push_back({m_par, in_data ^ m_lfsr});
        m_lfsr = model_step(m_lfsr);
        m_cnt  = m_cnt + 16'd1;
      end
    end
  end

  // Per-cycle comparison, mid-cycle when inputs and outputs are stable.
  always @(negedge clk) begin
    logic ev;
    ev = (mq.size() != 0);
    chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
    chk("in_ready", {31'b0, in_ready}, {31'b0, !seed_load && (!ev || out_ready)});
    chk("word_cnt", {16'b0, word_cnt}, {16'b0, m_cnt});
    if (ev) begin
      chk("out_data", out_data, mq[0][31:0]);
`ifdef XOR_DEC_PARITY_EN
      chk("out_perr", {31'b0, out_perr}, {31'b0, mq[0][32]});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] hold;
    logic [31:0] s;
    logic [31:0] d;

    // 1) reset, seed 1, known words
    reset = 1'b1;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_word_cnt", {16'b0, word_cnt}, 32'h0);
    reset = 1'b0; out_ready = 1'b1;
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    seed_load = 1'b1; seed_in = 32'h1;
    tick();
    seed_load = 1'b0; in_valid = 1'b1; in_data = 32'h0;
    tick();
    chk("t1_word0", out_data, 32'h0000_0001);
    in_data = 32'hFFFF_FFFF;
    tick();
    chk("t1_word1", out_data, 32'h7FDF_FFFC);
    chk("t1_cnt", {16'b0, word_cnt}, 32'd2);
    in_data = 32'h0;
    tick();
    chk("t1_next_key", out_data, 32'hC030_0002);
    in_valid = 1'b0;

    // 2) zero seed selects default
    seed_load = 1'b1; seed_in = 32'h0;
    tick();
    seed_load = 1'b0; in_valid = 1'b1; in_data = 32'h0;
    tick();
    chk("t2_default_seed", out_data, 32'hACE1_2345);
    in_valid = 1'b0;
    tick();

    // 3) backpressure for 5 cycles
    out_ready = 1'b0; in_valid = 1'b1; in_data = $urandom;
    tick();
    hold = out_data;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      #1;
      chk("t3_in_ready_low", {31'b0, in_ready}, 32'h0);
      tick();
      chk("t3_hold", out_data, hold);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    tick();

    // 4) back-to-back throughput and counter wrap
    seed_load = 1'b1; seed_in = $urandom;
    tick();
    seed_load = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = $urandom;
      tick();
    end
    chk("t4_cnt100", {16'b0, word_cnt}, 32'd100);
    for (int i = 0; i < 65435; i++) begin
      in_data = $urandom;
      tick();
    end
    chk("t4_cnt_max", {16'b0, word_cnt}, 32'h0000_FFFF);
    tick();
    chk("t4_cnt_wrap", {16'b0, word_cnt}, 32'h0);
    in_valid = 1'b0;
    tick();

    // 5) seed_load with a pending word and in_valid high
    out_ready = 1'b0; in_valid = 1'b1; in_data = $urandom;
    tick();
    s = $urandom | 32'h1;
    seed_load = 1'b1; seed_in = s; out_ready = 1'b1;
    #1 chk("t5_in_ready_low", {31'b0, in_ready}, 32'h0);
    tick();
    seed_load = 1'b0; d = $urandom; in_data = d;
    tick();
    chk("t5_new_seed", out_data, d ^ s);
    in_valid = 1'b0;

    // 6) reset with pending output
    out_ready = 1'b0; in_valid = 1'b1; in_data = $urandom;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_valid_cleared", {31'b0, out_valid}, 32'h0);
    chk("t6_cnt_cleared", {16'b0, word_cnt}, 32'h0);
    reset = 1'b0; out_ready = 1'b1;
`ifdef XOR_DEC_PARITY_EN
    in_data = 32'h1; in_parity = 1'b0;
    tick();
    chk("t6_perr_set", {31'b0, out_perr}, 32'h1);
    in_parity = 1'b1;
    tick();
    chk("t6_perr_clear", {31'b0, out_perr}, 32'h0);
`endif
    in_valid = 1'b0;
    tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      seed_load = ($urandom_range(0, 49) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      reset     = ($urandom_range(0, 499) == 0);
`ifdef XOR_DEC_PARITY_EN
      in_parity = $urandom_range(0, 1);
`endif
      tick();
    end
    reset = 1'b0; seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
